// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax normalisation stage.
package softmax_pkg;

  localparam int unsigned EXP_POS_W  = 5;
  localparam int unsigned EXP_MANT_W = 16;
  localparam int unsigned POS_SAT    = 16;

  typedef struct packed {
    logic [EXP_POS_W-1:0]  pos;
    logic [EXP_MANT_W-1:0] mant;
  } exp_word_t;

  typedef enum logic [1:0] {
    ACCUM,
    DIV,
    OUT
  } state_t;

endpackage

// File: rtl/softmax_div_seq.sv
// Restoring fractional divider: dividend/divisor as Q0.Q_W, one quotient bit per cycle, MSB first.
module softmax_div_seq #(
  parameter int unsigned DVD_W = 32,
  parameter int unsigned DVS_W = 36,
  parameter int unsigned Q_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(Q_W + 1);

  logic [DVS_W:0]   rem;
  logic [DVS_W:0]   rem2;
  logic             ge;
  logic [CNT_W-1:0] cnt;

  // rem never exceeds the divisor, so the doubled remainder fits in DVS_W+1 bits
  always_comb begin
    rem2 = rem << 1;
    ge   = rem2 >= {1'b0, divisor};
    done = busy && (cnt == CNT_W'(Q_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      rem      <= (DVS_W + 1)'(dividend);
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      rem      <= ge ? (rem2 - {1'b0, divisor}) : rem2;
      quotient <= {quotient[Q_W-2:0], ge};
      cnt      <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers a frame of exponent words, sums them, emits exp_i/sum in order.
// Optional SOFTMAX_NORM_ROUND_EN: one guard quotient bit and round-to-nearest.
module softmax_norm
  import softmax_pkg::*;
#(
  parameter int unsigned MAX_N = 16,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned LIN_W = 32,
  parameter int unsigned ACC_W = LIN_W + $clog2(MAX_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [20:0]      in_exp,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_prob,
  output logic             out_last,
  output logic             busy,
  output logic             ovf_flag,
  output logic             zero_sum_flag
);

  localparam int unsigned IDX_W = $clog2(MAX_N);
`ifdef SOFTMAX_NORM_ROUND_EN
  localparam int unsigned Q_W = OUT_W + 1;
`else
  localparam int unsigned Q_W = OUT_W;
`endif

  state_t               state, state_next;
  logic [LIN_W-1:0]     lin_buf [MAX_N];
  logic [ACC_W-1:0]     sum, sum_next;
  logic [IDX_W-1:0]     count, rd_idx, last_idx;
  exp_word_t            word;
  logic [EXP_POS_W-1:0] shamt;
  logic [LIN_W-1:0]     lin;
  logic [LIN_W-1:0]     cur;
  logic                 accept, frame_end, out_fire, last_out;
  logic                 div_start, div_busy, div_done;
  logic [Q_W-1:0]       div_q;
  logic [OUT_W-1:0]     rounded, result;

  always_comb begin
    word      = exp_word_t'(in_exp);
    shamt     = (word.pos > EXP_POS_W'(POS_SAT)) ? EXP_POS_W'(POS_SAT) : word.pos;
    lin       = LIN_W'(word.mant) << shamt;
    accept    = in_valid && (state == ACCUM);
    frame_end = in_last || (count == IDX_W'(MAX_N - 1));
    sum_next  = sum + ACC_W'(lin);
    out_fire  = (state == OUT) && out_ready;
    last_out  = (rd_idx == last_idx);
    cur       = lin_buf[rd_idx];
    div_start = (state == DIV) && !div_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && frame_end) state_next = DIV;
      DIV:     if (div_done) state_next = OUT;
      OUT:     if (out_ready) state_next = last_out ? ACCUM : DIV;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) lin_buf[count] <= lin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum           <= '0;
      count         <= '0;
      rd_idx        <= '0;
      last_idx      <= '0;
      ovf_flag      <= 1'b0;
      zero_sum_flag <= 1'b0;
    end else begin
      if (accept) begin
        sum   <= sum_next;
        count <= count + IDX_W'(1);
        if (count == '0) begin
          ovf_flag      <= 1'b0;
          zero_sum_flag <= 1'b0;
        end
        // frame_end without in_last can only mean the buffer filled up
        if (frame_end) begin
          last_idx      <= count;
          rd_idx        <= '0;
          count         <= '0;
          ovf_flag      <= !in_last;
          zero_sum_flag <= (sum_next == '0);
        end
      end
      if (out_fire) begin
        rd_idx <= rd_idx + IDX_W'(1);
        if (last_out) sum <= '0;
      end
    end
  end

  softmax_div_seq #(
    .DVD_W(LIN_W),
    .DVS_W(ACC_W),
    .Q_W  (Q_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(cur),
    .divisor (sum),
    .quotient(div_q),
    .busy    (div_busy),
    .done    (div_done)
  );

  always_comb begin
`ifdef SOFTMAX_NORM_ROUND_EN
    rounded = (&div_q[Q_W-1:1]) ? '1 : (div_q[Q_W-1:1] + OUT_W'(div_q[0]));
`else
    rounded = div_q;
`endif
    if (sum == '0)                result = '0;
    else if (ACC_W'(cur) == sum)  result = '1;
    else                          result = rounded;
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign out_prob  = (state == OUT) ? result : '0;
  assign out_last  = (state == OUT) && last_out;
  assign busy      = !((state == ACCUM) && (count == '0));

endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
Normalisation stage directly downstream of the per-element exponent approximator (softmax_8).
- Accepts a frame of exponent words, one per handshake: 5-bit position plus 16-bit mantissa.
- Converts each word to linear form, buffers it and accumulates the frame sum.
- Emits each element's probability exp_i / sum as an unsigned Q0.OUT_W fraction, in input order.
- Uses a sequential restoring divider, one quotient bit per cycle.

Parameters:
- MAX_N, 16, maximum elements per frame (power of 2, ≥2); sets buffer depth.
- OUT_W, 16, output probability width, Q0.OUT_W.
- LIN_W, 32, linear element width; L = mant << pos, pos ≤ 16.
- ACC_W, LIN_W+$clog2(MAX_N), sum accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_exp  in  21  [20:16] position, [15:0] mantissa, exactly as produced by softmax_8.
- in_last  in  1  marks the final word of the frame.
- out_valid  out  1  probability valid.
- out_ready  in  1  consumer accepts the probability.
- out_prob  out  OUT_W  probability, Q0.OUT_W.
- out_last  out  1  marks the final probability of the frame.
- busy  out  1  high in any state other than ACCUM with count = 0.
- ovf_flag  out  1  frame was force-closed at MAX_N.
- zero_sum_flag  out  1  frame sum was 0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_prob=0, out_last=0, busy=0, ovf_flag=0, zero_sum_flag=0; count=0, sum=0, state=ACCUM. Buffer contents are don't-care.
- Linear conversion: L = {16'b0, mant} << pos, truncated to LIN_W bits. Positions above 16 saturate the shift to 16.
- ACCUM state:
  - in_ready=1.
  - On in_valid&in_ready: buf[count] <= L, sum <= sum + L, count <= count + 1.
  - If in_last, or count = MAX_N-1, go to DIV next cycle with n = count + 1 and rd_idx = 0.
  - Force-close (count = MAX_N-1 without in_last) sets ovf_flag.
  - All flags are sticky for the frame and clear on the first accepted word of the next frame.
- DIV state:
  - in_ready=0.
  - Cycle 0 (load): rem <= buf[rd_idx], q <= 0.
  - Cycles 1..OUT_W, each cycle: rem2 = rem << 1; if rem2 ≥ sum then rem <= rem2 - sum and q bit = 1, else rem <= rem2 and q bit = 0. Bits are produced MSB first.
  - DIV therefore lasts exactly OUT_W+1 cycles per element, then go to OUT.
  - Saturation: if buf[rd_idx] == sum (single-element frame or all other elements zero), the result is 2^OUT_W-1.
  - Zero sum: if sum == 0, the result is 0 and zero_sum_flag=1.
  - Both special results are still produced on the fixed OUT_W+1 cycle schedule.
- OUT state:
  - out_valid=1; out_prob and out_last = (rd_idx == n-1) are held stable until out_ready.
  - On out_valid&out_ready: rd_idx++. If it was the last element, go to ACCUM with count=0 and sum=0; otherwise go to DIV.
- Throughput: OUT_W+2 cycles per output when out_ready is held high.
- No input is accepted while a frame is draining, so back-to-back frames do not overlap.
- Accumulator width ACC_W guarantees no sum overflow for n ≤ MAX_N.
- Divider compares against the full ACC_W-bit sum; rem is ACC_W+1 bits wide.
- Reset asserted mid-frame in any state: immediate return to reset values; the partial frame is discarded and no out_valid is produced for it.

Optional Feature:
- Macro: SOFTMAX_NORM_ROUND_EN.
- Defined: the divider runs one extra guard iteration (DIV lasts OUT_W+2 cycles) and rounds to nearest. q = q + guard, saturated at 2^OUT_W-1.
- Undefined: truncating quotient with the DIV timing above.

Decomposition:
- Package softmax_pkg holds:
  - exp_word_t, a struct with pos[4:0] and mant[15:0];
  - state enum {ACCUM, DIV, OUT};
  - constants EXP_POS_W=5, EXP_MANT_W=16, POS_SAT=16.
- Sub-module softmax_div_seq: restoring divider with start/done, parameterised on dividend, divisor and quotient widths. It is instantiated once.

Test Plan:
- Two words pos=0, mant=0x8000, in_last on the second → sum=0x10000; two outputs 0x8000, 0x8000 with out_last on the second; 18 cycles apart with out_ready=1.
- Four words pos=0, mants 0x1000, 0x1000, 0x2000, 0x4000 → outputs 0x2000, 0x2000, 0x4000, 0x8000.
- Single word pos=3, mant=0x1234, in_last → out_prob=0xFFFF, out_last=1.
- MAX_N=8, eight words without in_last → in_ready drops after the 8th word; ovf_flag=1; eight outputs.
- out_ready low for 5 cycles during OUT → out_valid and out_prob stable throughout; no skipped element.
- rst_n pulsed low in the middle of DIV → all outputs at reset values; the next frame (mants 2, 1, pos=0) yields 0xAAAA, 0x5555. With SOFTMAX_NORM_ROUND_EN it yields 0xAAAB, 0x5555.
